// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader.
//   state_t           : loader FSM states
//   SYNC_BYTE_DEFAULT : default frame start marker
//   csum_add          : 8-bit modular checksum accumulate
package prog_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      CHECK,
      DONE,
      ERR
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a framed program image and writes it
// byte by byte into instruction memory, holding the CPU in reset until a
// frame with a correct checksum has been loaded.
//
// Frame: SYNC_BYTE, LEN_LO, LEN_HI, LEN payload bytes, CSUM (sum mod 256).
//
// Ports
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   in_valid/in_data/in_ready: byte stream, transfer on valid & ready
//   insMemEn                 : one-cycle byte write strobe
//   insMemAddr/insMemData    : byte address / zero-extended write byte
//   cpu_reset                : high while no valid program is loaded
//   done / error             : outcome of the last frame
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for sync byte, nothing loaded since reset
// LEN_LO | expecting low length byte
// LEN_HI | expecting high length byte, length range check
// DATA   | receiving payload, one memory write per byte
// CSUM   | expecting checksum byte
// CHECK  | comparing checksum, stream stalled for this one cycle
// DONE   | program loaded, CPU released; new sync restarts loading
// ERR    | frame rejected, CPU held in reset; new sync restarts loading
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int         WIDTH      = 32,
   parameter int         IMEM_DEPTH = 4096,
   parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             insMemEn,
   output logic [WIDTH-1:0] insMemAddr,
   output logic [WIDTH-1:0] insMemData,
   output logic             cpu_reset,
   output logic             done,
   output logic             error
);

   state_t state_q, state_d;

   logic [15:0]      len_q, len_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [7:0]       sum_q, sum_d;
   logic [7:0]       csum_q, csum_d;

   logic             in_ready_q, in_ready_d;
   logic             mem_en_q, mem_en_d;
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0] mem_data_q, mem_data_d;
   logic             cpu_reset_q, cpu_reset_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic             accept;
   logic [16:0]      len_full;

   assign accept   = in_valid & in_ready_q;
   // Extra bit so the range check cannot wrap for any IMEM_DEPTH up to 64 KiB.
   assign len_full = {1'b0, in_data, len_q[7:0]};

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      csum_d      = csum_q;
      mem_en_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      cpu_reset_d = cpu_reset_q;
      done_d      = done_q;
      error_d     = error_q;

      case (state_q)
         IDLE, DONE, ERR: begin
            if (accept && in_data == SYNC_BYTE) begin
               state_d     = LEN_LO;
               done_d      = 1'b0;
               error_d     = 1'b0;
               cpu_reset_d = 1'b1;
               len_d       = '0;
               cnt_d       = '0;
               sum_d       = '0;
               csum_d      = '0;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_d   = {8'h00, in_data};
               state_d = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d = len_full[15:0];
               if (len_full == '0) begin
                  state_d = CSUM;
               end else if (len_full > 17'(IMEM_DEPTH)) begin
                  state_d     = ERR;
                  error_d     = 1'b1;
                  cpu_reset_d = 1'b1;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               mem_en_d   = 1'b1;
               mem_addr_d = WIDTH'(cnt_q);
               mem_data_d = WIDTH'(in_data);
               sum_d      = csum_add(sum_q, in_data);
               cnt_d      = cnt_q + 16'd1;
               if (cnt_q + 16'd1 == len_q) begin
                  state_d = CSUM;
               end
            end
         end
         CSUM: begin
            if (accept) begin
               csum_d  = in_data;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (csum_q == sum_q) begin
               state_d     = DONE;
               done_d      = 1'b1;
               cpu_reset_d = 1'b0;
            end else begin
               state_d     = ERR;
               error_d     = 1'b1;
               cpu_reset_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Registered ready follows the state being entered, so it is low
      // exactly for the single cycle spent in CHECK.
      in_ready_d = (state_d != CHECK);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         sum_q       <= '0;
         csum_q      <= '0;
         in_ready_q  <= 1'b1;
         mem_en_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         csum_q      <= csum_d;
         in_ready_q  <= in_ready_d;
         mem_en_q    <= mem_en_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign insMemEn   = mem_en_q;
   assign insMemAddr = mem_addr_q;
   assign insMemData = mem_data_q;
   assign cpu_reset  = cpu_reset_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: the driver pushes expected memory writes
// and frame outcomes into queues, a negedge monitor pops and compares them
// whenever the DUT strobes a write or raises done/error.
module tb_prog_loader;
   import prog_loader_pkg::*;

   localparam int WIDTH      = 32;
   localparam int IMEM_DEPTH = 4096;

   logic             clock    = 1'b0;
   logic             reset    = 1'b1;
   logic             in_valid = 1'b0;
   logic [7:0]       in_data  = 8'h00;
   logic             in_ready;
   logic             insMemEn;
   logic [WIDTH-1:0] insMemAddr;
   logic [WIDTH-1:0] insMemData;
   logic             cpu_reset;
   logic             done;
   logic             error;

   prog_loader #(
      .WIDTH      (WIDTH),
      .IMEM_DEPTH (IMEM_DEPTH),
      .SYNC_BYTE  (8'hA5)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .insMemEn   (insMemEn),
      .insMemAddr (insMemAddr),
      .insMemData (insMemData),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .error      (error)
   );

   always #5 clock = ~clock;

   int     checks   = 0;
   int     failures = 0;
   longint cyc      = 0;

   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [WIDTH-1:0] addr;
      logic [WIDTH-1:0] data;
      longint           cyc;
   } wr_t;

   typedef struct {
      logic done;
      logic err;
      logic cpu_rst;
   } st_t;

   wr_t wr_q[$];
   st_t st_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor
   logic fin_prev = 1'b0;
   always @(negedge clock) begin
      wr_t w;
      st_t s;
      if (insMemEn === 1'b1) begin
         if (wr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write addr=%0h data=%0h", insMemAddr, insMemData);
         end else begin
            w = wr_q.pop_front();
            chk("wr_addr", insMemAddr, w.addr);
            chk("wr_data", insMemData, w.data);
            chk("wr_cycle", cyc, w.cyc);
         end
      end
      if ((done | error) === 1'b1 && !fin_prev) begin
         if (st_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_status done=%0b error=%0b", done, error);
         end else begin
            s = st_q.pop_front();
            chk("st_done", done, s.done);
            chk("st_error", error, s.err);
            chk("st_cpu_reset", cpu_reset, s.cpu_rst);
         end
      end
      fin_prev <= ((done | error) === 1'b1);
   end

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_en", insMemEn, 0);
      chk("rst_addr", insMemAddr, 0);
      chk("rst_data", insMemData, 0);
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rnd, output longint acc_cyc);
      int budget = 0;
      if (rnd) begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clock);
            in_data = 8'($urandom);
         end
      end
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && budget < 16) begin
         @(negedge clock);
         budget++;
      end
      if (in_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout byte=%0h in_ready=%0b", b, in_ready);
      end
      @(posedge clock);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   // fb: bytes to send; nw: payload bytes expected as writes (from index 3);
   // chk_ready: expect the one-cycle CHECK stall after the last byte.
   task automatic send_frame(input logic [7:0] fb[$], input int nw, input bit has_st,
                             input st_t st, input bit chk_ready, input bit rnd);
      longint t;
      int     budget = 0;
      if (has_st) st_q.push_back(st);
      foreach (fb[i]) begin
         send_byte(fb[i], rnd, t);
         if (i >= 3 && i < 3 + nw)
            wr_q.push_back('{addr: WIDTH'(i - 3), data: WIDTH'(fb[i]), cyc: t});
      end
      if (chk_ready) begin
         @(negedge clock);
         chk("ready_low_in_check", in_ready, 0);
         @(negedge clock);
         chk("ready_high_after_check", in_ready, 1);
      end
      while ((wr_q.size() + st_q.size()) != 0 && budget < 20) begin
         @(negedge clock);
         budget++;
      end
      chk("scoreboard_drained", wr_q.size() + st_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] f[$];
      logic [7:0] sum;
      st_t ok;
      st_t bad;
      ok  = '{done: 1'b1, err: 1'b0, cpu_rst: 1'b0};
      bad = '{done: 1'b0, err: 1'b1, cpu_rst: 1'b1};

      do_reset();

      // Basic good frame
      f = '{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
      send_frame(f, 4, 1'b1, ok, 1'b1, 1'b0);

      // Bad checksum: writes still happen, frame rejected
      f[7] = 8'h14;
      send_frame(f, 4, 1'b1, bad, 1'b1, 1'b0);

      // LEN = 4097: rejected straight after LEN_HI, no writes
      f = '{8'hA5, 8'h01, 8'h10};
      send_frame(f, 0, 1'b1, bad, 1'b0, 1'b0);

      // Zero-length frame, good and bad checksum
      f = '{8'hA5, 8'h00, 8'h00, 8'h00};
      send_frame(f, 0, 1'b1, ok, 1'b1, 1'b0);
      f = '{8'hA5, 8'h00, 8'h00, 8'h01};
      send_frame(f, 0, 1'b1, bad, 1'b1, 1'b0);

      // Checksum wraps: FF+02+10 = 0x111 -> 0x11
      f = '{8'hA5, 8'h03, 8'h00, 8'hFF, 8'h02, 8'h10, 8'h11};
      send_frame(f, 3, 1'b1, ok, 1'b1, 1'b0);

      // Garbage in DONE is ignored, done stays up
      f = '{8'h00, 8'hFF, 8'h12};
      send_frame(f, 0, 1'b0, ok, 1'b0, 1'b0);
      @(negedge clock);
      chk("garbage_done_hold", done, 1);
      chk("garbage_no_cpu_reset", cpu_reset, 0);

      // Same frame with random valid gaps
      f = '{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
      send_frame(f, 4, 1'b1, ok, 1'b1, 1'b1);

      // Reset after two payload bytes, then a full frame restarts at address 0
      f = '{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00};
      send_frame(f, 2, 1'b0, ok, 1'b0, 1'b0);
      do_reset();
      chk("no_writes_after_reset", wr_q.size(), 0);
      f = '{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
      send_frame(f, 4, 1'b1, ok, 1'b1, 1'b0);

      // Maximum length frame: addresses 0..IMEM_DEPTH-1
      f   = '{8'hA5, 8'h00, 8'h10};
      sum = 8'h00;
      for (int i = 0; i < IMEM_DEPTH; i++) begin
         f.push_back(8'(i * 7 + 3));
         sum = sum + 8'(i * 7 + 3);
      end
      f.push_back(sum);
      send_frame(f, IMEM_DEPTH, 1'b1, ok, 1'b1, 1'b0);
      @(negedge clock);
      chk("max_last_addr", insMemAddr, IMEM_DEPTH - 1);

      repeat (3) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
